// File: rtl/sprite_draw_scheduler.sv
// rtl/sprite_draw_scheduler.sv - round-robin sprite erase/draw scheduler for a shared VGA plot port
module sprite_draw_scheduler #(
   parameter int NUM_REQ = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   x_tile,
   input  logic [7*NUM_REQ-1:0]   y_tile,
   input  logic [25*NUM_REQ-1:0]  shape,
   input  logic [3*NUM_REQ-1:0]   colour,
   output logic [NUM_REQ-1:0]     ack,
   output logic                   err,
   output logic                   busy,
   output logic [7:0]             x_out,
   output logic [6:0]             y_out,
   output logic [2:0]             col_out,
   output logic                   plot
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW, DONE} state_t;

   state_t              state;
   logic [IW-1:0]       rr;
   logic [IW-1:0]       winner;
   logic [IW-1:0]       pick;
   logic [IW-1:0]       scan;
   logic                found;
   logic [NUM_REQ-1:0]  pending;
   logic [NUM_REQ-1:0]  old_valid;
   logic [NUM_REQ-1:0]  clr;
   logic [NUM_REQ-1:0]  win_hot;
   logic [NUM_REQ-1:0]  pick_hot;
   logic [7:0]          old_x [NUM_REQ];
   logic [6:0]          old_y [NUM_REQ];
   logic [7:0]          xs [NUM_REQ];
   logic [6:0]          ys [NUM_REQ];
   logic [24:0]         ss [NUM_REQ];
   logic [2:0]          cs [NUM_REQ];
   logic [7:0]          new_x;
   logic [6:0]          new_y;
   logic [24:0]         new_shape;
   logic [2:0]          new_colour;
   logic [2:0]          r, c, nr, nc;
   logic                last;
   logic                bad;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign xs[g] = x_tile[8*g +: 8];
      assign ys[g] = y_tile[7*g +: 7];
      assign ss[g] = shape[25*g +: 25];
      assign cs[g] = colour[3*g +: 3];
   end

   function automatic logic [7:0] px(input logic [7:0] t, input logic [2:0] k);
      return t * 8'd5 + {5'd0, k};
   endfunction

   function automatic logic [6:0] py(input logic [6:0] t, input logic [2:0] k);
      return t * 7'd5 + {4'd0, k};
   endfunction

   // Bit 24 is the top-left pixel; the bitmap is scanned row-major.
   function automatic logic [2:0] pcol(input logic [24:0] s, input logic [2:0] col,
                                       input logic [2:0] row, input logic [2:0] clm);
      logic [4:0] i;
      i = 5'd24 - (5'(row) * 5'd5 + 5'(clm));
      return s[i] ? col : 3'd0;
   endfunction

   always_comb begin
      found = 1'b0;
      pick  = '0;
      scan  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = IW'((int'(rr) + k) % NUM_REQ);
         if (!found && pending[scan]) begin
            found = 1'b1;
            pick  = scan;
         end
      end
   end

   assign win_hot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
   assign pick_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
   assign clr      = (state == IDLE && found) ? pick_hot : '0;
   assign bad      = (xs[winner] > 8'd31) || (ys[winner] > 7'd23);
   assign last     = (r == 3'd4) && (c == 3'd4);
   assign nc       = (c == 3'd4) ? 3'd0 : c + 3'd1;
   assign nr       = (c == 3'd4) ? r + 3'd1 : r;

   // Outputs are loaded for the state being entered so they line up with it.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         rr         <= '0;
         winner     <= '0;
         pending    <= '0;
         old_valid  <= '0;
         new_x      <= '0;
         new_y      <= '0;
         new_shape  <= '0;
         new_colour <= '0;
         r          <= '0;
         c          <= '0;
         ack        <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         x_out      <= '0;
         y_out      <= '0;
         col_out    <= '0;
         plot       <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            old_x[i] <= '0;
            old_y[i] <= '0;
         end
      end else begin
         ack     <= '0;
         err     <= 1'b0;
         pending <= (pending & ~clr) | req;
         case (state)
            IDLE: begin
               if (found) begin
                  winner <= pick;
                  busy   <= 1'b1;
                  state  <= LATCH;
               end
            end
            LATCH: begin
               new_x      <= xs[winner];
               new_y      <= ys[winner];
               new_shape  <= ss[winner];
               new_colour <= cs[winner];
               r          <= '0;
               c          <= '0;
               if (bad) begin
                  ack   <= win_hot;
                  err   <= 1'b1;
                  rr    <= (winner == IW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
                  state <= DONE;
               end else if (old_valid[winner]) begin
                  plot    <= 1'b1;
                  x_out   <= px(old_x[winner], 3'd0);
                  y_out   <= py(old_y[winner], 3'd0);
                  col_out <= 3'd0;
                  state   <= ERASE;
               end else begin
                  plot    <= 1'b1;
                  x_out   <= px(xs[winner], 3'd0);
                  y_out   <= py(ys[winner], 3'd0);
                  col_out <= pcol(ss[winner], cs[winner], 3'd0, 3'd0);
                  state   <= DRAW;
               end
            end
            ERASE: begin
               if (last) begin
                  r       <= '0;
                  c       <= '0;
                  x_out   <= px(new_x, 3'd0);
                  y_out   <= py(new_y, 3'd0);
                  col_out <= pcol(new_shape, new_colour, 3'd0, 3'd0);
                  state   <= DRAW;
               end else begin
                  r       <= nr;
                  c       <= nc;
                  x_out   <= px(old_x[winner], nc);
                  y_out   <= py(old_y[winner], nr);
                  col_out <= 3'd0;
               end
            end
            DRAW: begin
               if (last) begin
                  plot              <= 1'b0;
                  x_out             <= '0;
                  y_out             <= '0;
                  col_out           <= '0;
                  ack               <= win_hot;
                  rr                <= (winner == IW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
                  old_x[winner]     <= new_x;
                  old_y[winner]     <= new_y;
                  old_valid[winner] <= 1'b1;
                  state             <= DONE;
               end else begin
                  r       <= nr;
                  c       <= nc;
                  x_out   <= px(new_x, nc);
                  y_out   <= py(new_y, nr);
                  col_out <= pcol(new_shape, new_colour, nr, nc);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb/tb_sprite_draw_scheduler.sv - directed and randomized checks of sprite_draw_scheduler against a pixel-list model
module tb_sprite_draw_scheduler;
   localparam int N = 4;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [8*N-1:0]  x_tile;
   logic [7*N-1:0]  y_tile;
   logic [25*N-1:0] shape;
   logic [3*N-1:0]  colour;
   logic [N-1:0]    ack;
   logic            err;
   logic            busy;
   logic [7:0]      x_out;
   logic [6:0]      y_out;
   logic [2:0]      col_out;
   logic            plot;

   logic [7:0]  tx [N];
   logic [6:0]  ty [N];
   logic [24:0] tshape [N];
   logic [2:0]  tcol [N];

   int  n_assert = 0;
   int  n_fail = 0;
   int  m_rr;
   bit  m_valid [N];
   int  m_ox [N];
   int  m_oy [N];
   logic [17:0] exp_q [$];
   logic [17:0] got_q [$];
   bit  exp_rej;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign x_tile[8*g +: 8]  = tx[g];
      assign y_tile[7*g +: 7]  = ty[g];
      assign shape[25*g +: 25] = tshape[g];
      assign colour[3*g +: 3]  = tcol[g];
   end

   sprite_draw_scheduler #(.NUM_REQ(N)) dut (
      .clock(clock), .reset_n(reset_n), .req(req),
      .x_tile(x_tile), .y_tile(y_tile), .shape(shape), .colour(colour),
      .ack(ack), .err(err), .busy(busy),
      .x_out(x_out), .y_out(y_out), .col_out(col_out), .plot(plot)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] p, input int rr);
      for (int k = 0; k < N; k++) begin
         if (p[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   // Expected pixel stream for owner o: optional erase of the old tile, then the new shape.
   task automatic build(input int o);
      exp_q.delete();
      exp_rej = (tx[o] > 31) || (ty[o] > 23);
      if (!exp_rej) begin
         if (m_valid[o])
            for (int r = 0; r < 5; r++)
               for (int c = 0; c < 5; c++)
                  exp_q.push_back({8'(m_ox[o]*5 + c), 7'(m_oy[o]*5 + r), 3'b000});
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               exp_q.push_back({8'(tx[o]*5 + c), 7'(ty[o]*5 + r),
                                tshape[o][24-(5*r+c)] ? tcol[o] : 3'b000});
      end
   endtask

   task automatic serve(input logic [N-1:0] first, input logic [N-1:0] late, input int late_at);
      logic [N-1:0] mp;
      int cur, idx, exp_at, guard;
      mp = first;
      @(negedge clock); req = first;
      @(posedge clock);
      @(negedge clock); req = '0; idx = 0;
      cur = pick(mp, m_rr);
      mp[cur] = 1'b0;
      build(cur);
      exp_at = 2 + exp_q.size();
      got_q.delete();
      guard = 0;
      while (cur >= 0 && guard < 600) begin
         if (idx == late_at && late != '0) begin
            req = late;
            mp = mp | late;
         end
         @(posedge clock);
         @(negedge clock); req = '0; idx++; guard++;
         if (plot) got_q.push_back({x_out, y_out, col_out});
         if (ack != '0 || err) begin
            check("ack_owner", 32'(ack), 32'(1 << cur));
            check("err", 32'(err), 32'(exp_rej));
            check("ack_cycle", idx, exp_at);
            check("plot_count", got_q.size(), exp_q.size());
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
               check("pixel", 32'(got_q[i]), 32'(exp_q[i]));
               if (got_q[i] !== exp_q[i]) break;
            end
            if (!exp_rej) begin
               m_valid[cur] = 1'b1;
               m_ox[cur] = tx[cur];
               m_oy[cur] = ty[cur];
            end
            m_rr = (cur + 1) % N;
            got_q.delete();
            cur = pick(mp, m_rr);
            if (cur >= 0) begin
               mp[cur] = 1'b0;
               build(cur);
               exp_at = idx + 3 + exp_q.size();
            end
         end
      end
      if (cur >= 0) check("serve_timeout", guard, 0);
      @(posedge clock);
      @(negedge clock);
      check("idle_after", 32'(busy), 32'(0));
   endtask

   task automatic randomize_owners();
      for (int i = 0; i < N; i++) begin
         tx[i] = 8'($urandom_range(0, 33));
         ty[i] = 7'($urandom_range(0, 25));
         tshape[i] = 25'($urandom);
         tcol[i] = 3'($urandom);
      end
   endtask

   initial begin
      int cnt, target, guard;
      logic [N-1:0] acc;
      for (int i = 0; i < N; i++) begin
         tx[i] = '0; ty[i] = '0; tshape[i] = '0; tcol[i] = '0;
         m_valid[i] = 1'b0; m_ox[i] = 0; m_oy[i] = 0;
      end
      m_rr = 0;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_outputs", {7'b0, ack, err, busy, plot, x_out, y_out, col_out}, 32'(0));
      reset_n = 1'b1;

      tx[0] = 8'd0; ty[0] = 7'd0; tshape[0] = 25'h1FFFFFF; tcol[0] = 3'b110;
      serve(4'b0001, '0, 0);
      tx[0] = 8'd1; tshape[0] = 25'h0EFE3EE;
      serve(4'b0001, '0, 0);

      tx[2] = 8'd32; ty[2] = 7'd5; tshape[2] = 25'h1555555; tcol[2] = 3'b011;
      serve(4'b0100, '0, 0);
      tx[2] = 8'd10;
      serve(4'b0100, '0, 0);

      tx[1] = 8'd4;  ty[1] = 7'd7;  tshape[1] = 25'h0F0F0F0; tcol[1] = 3'b001;
      tx[3] = 8'd31; ty[3] = 7'd23; tshape[3] = 25'h1F0001F; tcol[3] = 3'b111;
      m_rr = m_rr;
      serve(4'b1111, '0, 0);
      serve(4'b1111, '0, 0);
      serve(4'b0010, 4'b1001, 5);

      for (int it = 0; it < 8; it++) begin
         randomize_owners();
         serve(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 1);
      end

      tx[0] = 8'd3; ty[0] = 7'd2; tshape[0] = 25'h1ABCDEF; tcol[0] = 3'b101;
      @(negedge clock); req = 4'b0001;
      @(posedge clock);
      @(negedge clock); req = '0;
      cnt = 0;
      guard = 0;
      target = (m_valid[0] ? 25 : 0) + 11;
      while (cnt < target && guard < 200) begin
         @(posedge clock);
         @(negedge clock);
         guard++;
         if (plot) cnt++;
      end
      check("abort_reached", cnt, target);
      reset_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("abort_plot", 32'(plot), 32'(0));
      check("abort_busy", 32'(busy), 32'(0));
      acc = ack;
      reset_n = 1'b1;
      repeat (60) begin
         @(posedge clock);
         @(negedge clock);
         acc = acc | ack;
      end
      check("abort_no_ack", 32'(acc), 32'(0));
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_rr = 0;
      serve(4'b0001, '0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
